// File: rtl/fpu_pkg.sv
// Shared types and FP32 constants for the FPU add/sub arbitration slice.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package fpu_pkg;

    typedef enum logic {
        FPU_ADD = 1'b0,
        FPU_SUB = 1'b1
    } fpu_op_e;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] CAN_NAN  = 32'h7FC0_0000;

    // Wide enough for the largest supported requester count (8).
    localparam int RSP_ID_W = 3;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [31:0]         result;
        logic                exception;
    } fpu_rsp_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with occupancy count; head is shown without bypass.
// Latency: a push is visible at the head one cycle after the push edge.
// Backpressure: rd_vld/rd_rdy on the read side; writer must never push when full.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          pop;

    assign pop    = rd_vld && rd_rdy;
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset because cnt qualifies the head.
    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
// Latency: grant is combinational; the pointer moves on the advance edge.
// Backpressure: enable low forces an all-zero grant and holds the pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int W = $clog2(N);

    logic [W-1:0]   last_grant;
    logic [W-1:0]   start;
    logic [W-1:0]   gnt_idx;
    logic [2*N-1:0] rot;
    logic           found;
    int             sel;

    // Rotate the request vector so index 0 is the first candidate, then pick the lowest.
    always_comb begin
        start = (last_grant == W'(N-1)) ? '0 : last_grant + 1'b1;
        rot   = {req, req} >> start;
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sel   = k + int'(start);
            end
        end
        if (sel >= N) sel = sel - N;
        gnt_idx = W'(sel);
        grant   = (enable && found) ? (N'(1) << gnt_idx) : '0;
    end

    // Pointer starts at N-1 so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst)          last_grant <= W'(N-1);
        else if (advance) last_grant <= gnt_idx;
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one FPU add/sub datapath among NUM_REQ requesters; optional macro FPU_ARB_EXC_STATS_EN.
// Latency: fire to rsp_valid is FPU_LAT+1 cycles, responses in issue order.
// Backpressure: grants stop when in-flight plus buffered results reach RSP_DEPTH.
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int FPU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*32-1:0]        req_a,
    input  logic [NUM_REQ*32-1:0]        req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic [31:0]                  fpu_a,
    output logic [31:0]                  fpu_b,
    output logic                         fpu_op,
    input  logic [31:0]                  fpu_result,
    input  logic                         fpu_exception,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [31:0]                  rsp_result,
    output logic                         rsp_exception,
    output logic [NUM_REQ*16-1:0]        exc_count
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(RSP_DEPTH) + 1;

    logic [NUM_REQ-1:0] grant;
    logic               fire;
    logic               arb_en;
    logic               credit_ok;
    logic               pop;
    logic [IDW-1:0]     fire_id;
    fpu_op_e            sel_op;
    logic [FPU_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [FPU_LAT];
    fpu_rsp_t           push_rsp;
    fpu_rsp_t           head_rsp;
    logic               head_vld;
    logic [CW-1:0]      fifo_count;
    int                 occupancy;
    logic               unused_id_hi;

    assign pop = head_vld && rsp_ready;

    // Credit: every issued op owns a FIFO slot until popped; a same-cycle pop frees one.
    always_comb begin
        occupancy = int'(fifo_count);
        for (int k = 0; k < FPU_LAT; k++) begin
            occupancy = occupancy + (tag_vld[k] ? 1 : 0);
        end
        credit_ok = pop ? (occupancy <= RSP_DEPTH) : (occupancy < RSP_DEPTH);
    end

    assign arb_en = !rst && credit_ok;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .enable  (arb_en),
        .advance (fire),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    // Operand mux of the granted requester; idle cycles drive a zero add.
    always_comb begin
        fire_id = '0;
        fpu_a   = '0;
        fpu_b   = '0;
        sel_op  = FPU_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fire_id = IDW'(i);
                fpu_a   = req_a[i*32 +: 32];
                fpu_b   = req_b[i*32 +: 32];
                sel_op  = fpu_op_e'(req_op[i]);
            end
        end
    end

    assign fpu_op = sel_op;

    // Tag valids track the FPU pipeline; clearing them discards results already in the FPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= fire;
            for (int k = 1; k < FPU_LAT; k++) tag_vld[k] <= tag_vld[k-1];
        end
    end

    // Tag IDs ride alongside the valids; only meaningful where the valid is set.
    always_ff @(posedge clk) begin
        tag_id[0] <= fire_id;
        for (int k = 1; k < FPU_LAT; k++) tag_id[k] <= tag_id[k-1];
    end

    // Assemble the response from the last tag stage and the FPU outputs.
    always_comb begin
        push_rsp           = '0;
        push_rsp.id        = RSP_ID_W'(tag_id[FPU_LAT-1]);
        push_rsp.result    = fpu_result;
        push_rsp.exception = fpu_exception;
    end

    fifo #(.W($bits(fpu_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tag_vld[FPU_LAT-1]),
        .wr_dat (push_rsp),
        .rd_vld (head_vld),
        .rd_rdy (rsp_ready),
        .rd_dat (head_rsp),
        .count  (fifo_count)
    );

    // Stale FIFO storage is masked so an empty port always reads as zero.
    assign rsp_valid     = head_vld;
    assign rsp_id        = head_vld ? head_rsp.id[IDW-1:0] : '0;
    assign rsp_result    = head_vld ? head_rsp.result : '0;
    assign rsp_exception = head_vld && head_rsp.exception;
    assign unused_id_hi  = ^head_rsp.id;

`ifdef FPU_ARB_EXC_STATS_EN
    logic [15:0] exc_cnt [NUM_REQ];

    // Saturating per-requester exception counters, counted at response pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) exc_cnt[i] <= '0;
        end else if (pop && head_rsp.exception) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head_rsp.id[IDW-1:0] == IDW'(i) && exc_cnt[i] != 16'hFFFF)
                    exc_cnt[i] <= exc_cnt[i] + 16'd1;
            end
        end
    end

    // Flatten the counters onto the output bus, requester i in slice i.
    always_comb begin
        exc_count = '0;
        for (int i = 0; i < NUM_REQ; i++) exc_count[i*16 +: 16] = exc_cnt[i];
    end
`else
    assign exc_count = '0;
`endif

endmodule
